// File: rtl/mio_responder.sv
// Memory/IO responder: decodes one CPU bus request into a RAM access or an
// IO register access (LED, switches, free-running counter) and returns a ready pulse.
module mio_responder #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic              cpu_mio,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [1:0]        dbg_state
);

  // Handshake: the CPU holds mem_r/mem_w (qualified by cpu_mio) until mio_ready;
  // a request is sampled only in IDLE, and mio_ready/bus_err pulse for exactly one cycle.

  localparam logic [31:0] LED_ADDR  = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hE000_0004;
  localparam logic [31:0] CNT_ADDR  = 32'hE000_0008;
  localparam logic [63:0] RAM_LIMIT = 64'd4 << RAM_AW;
  localparam logic [3:0]  RAM_LOAD  = 4'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM = 3'd0,
    TGT_LED = 3'd1,
    TGT_SW  = 3'd2,
    TGT_CNT = 3'd3,
    TGT_ERR = 3'd4
  } tgt_e;

  state_e      state;
  tgt_e        tgt_d;
  tgt_e        tgt_q;
  logic        wr_q;
  logic [3:0]  lat_q;
  logic [31:0] cnt;
  logic [31:0] rd_val;
  logic        req_any;

  assign req_any   = cpu_mio && (mem_r || mem_w);
  assign dbg_state = state;

  // Decode the live request; both strobes set is always an error.
  always_comb begin
    tgt_d = TGT_ERR;
    if (!(mem_r && mem_w) && (addr[1:0] == 2'b00)) begin
      if ((addr[31:28] == 4'h0) && ({32'd0, addr} < RAM_LIMIT)) tgt_d = TGT_RAM;
      else if (addr == LED_ADDR)                                  tgt_d = TGT_LED;
      else if (addr == SW_ADDR)                                   tgt_d = TGT_SW;
      else if (addr == CNT_ADDR)                                  tgt_d = TGT_CNT;
      else                                                        tgt_d = TGT_ERR;
    end
  end

  always_comb begin
    rd_val = 32'd0;
    if (!wr_q) begin
      case (tgt_q)
        TGT_RAM: rd_val = ram_rdata;
        TGT_LED: rd_val = {16'd0, led_out};
        TGT_SW:  rd_val = {16'd0, sw_in};
        TGT_CNT: rd_val = cnt;
        default: rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tgt_q     <= TGT_ERR;
      wr_q      <= 1'b0;
      lat_q     <= 4'd0;
      cnt       <= 32'd0;
      rdata     <= 32'd0;
      mio_ready <= 1'b0;
      bus_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
      led_out   <= 16'd0;
    end else begin
      cnt       <= cnt + 32'd1;
      mio_ready <= 1'b0;
      bus_err   <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            tgt_q     <= tgt_d;
            wr_q      <= mem_w && !mem_r;
            ram_addr  <= addr[RAM_AW+1:2];
            ram_wdata <= wdata;
            lat_q     <= (tgt_d == TGT_RAM) ? RAM_LOAD : 4'd0;
            ram_we    <= (tgt_d == TGT_RAM) && mem_w;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_q == 4'd0) begin
            state     <= DONE;
            mio_ready <= 1'b1;
            bus_err   <= (tgt_q == TGT_ERR);
            rdata     <= rd_val;
            if (wr_q && (tgt_q == TGT_LED)) led_out <= ram_wdata[15:0];
            // The clear overrides this cycle's increment above.
            if (wr_q && (tgt_q == TGT_CNT)) cnt <= 32'd0;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Bench for mio_responder: directed scenarios plus randomized traffic checked
// against a transaction-level model of the address map, RAM contents and counter.
module tb_mio_responder;

  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam logic [31:0] LED_A = 32'hE000_0000;
  localparam logic [31:0] SW_A  = 32'hE000_0004;
  localparam logic [31:0] CNT_A = 32'hE000_0008;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_r = 1'b0;
  logic              mem_w = 1'b0;
  logic              cpu_mio = 1'b0;
  logic [31:0]       addr = 32'd0;
  logic [31:0]       wdata = 32'd0;
  logic [31:0]       rdata;
  logic              mio_ready;
  logic              bus_err;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'd0;
  logic [15:0]       sw_in = 16'd0;
  logic [15:0]       led_out;
  logic [1:0]        dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [15:0] ref_led = 16'd0;
  int          clr_edge = 0;

  logic [31:0] tb_ram [0:(1<<RAM_AW)-1] = '{default: 32'd0};

  mio_responder #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .cpu_mio(cpu_mio),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready),
    .bus_err(bus_err), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out), .dbg_state(dbg_state)
  );

  // Clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction-level prediction; done_edge is the edge that closed ACCESS.
  function automatic void predict(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input int done_edge,
                                  output logic [31:0] e_rd, output logic e_err,
                                  output int e_lat, output int e_we);
    int idx;
    e_rd = 32'd0; e_err = 1'b0; e_lat = 2; e_we = 0;
    idx = int'(a >> 2);
    if (r && w) e_err = 1'b1;
    else if (a[1:0] != 2'b00) e_err = 1'b1;
    else if ({32'd0, a} < (64'd4 << RAM_AW)) begin
      e_lat = RAM_LAT + 1;
      if (w) begin
        ref_mem[idx] = d;
        e_we = 1;
      end else begin
        e_rd = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
      end
    end else if (a == LED_A) begin
      if (w) ref_led = d[15:0];
      else e_rd = {16'd0, ref_led};
    end else if (a == SW_A) begin
      if (!w) e_rd = {16'd0, sw_in};
    end else if (a == CNT_A) begin
      if (w) clr_edge = done_edge;
      else e_rd = 32'(done_edge - 1 - clr_edge);
    end else e_err = 1'b1;
  endfunction

  // Driver + checks for one complete transaction
  task automatic txn(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    logic [31:0] rd, wa, wd, e_rd;
    logic err, e_err;
    int lat, wn, wc, de, st, e_lat, e_we;
    rd = 32'd0; wa = 32'd0; wd = 32'd0; err = 1'b0;
    lat = 0; wn = 0; wc = 0; de = 0; st = 0;
    @(negedge clk);
    cpu_mio = 1'b1; mem_r = r; mem_w = w; addr = a; wdata = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr = $urandom;
        wdata = $urandom;
      end
      if (ram_we) begin
        wn++;
        if (wc == 0) wc = n;
        wa = 32'(ram_addr);
        wd = ram_wdata;
      end
      if (mio_ready) begin
        lat = n; rd = rdata; err = bus_err; de = cyc;
        break;
      end
    end
    // Request stays held across the DONE cycle's closing edge.
    @(negedge clk);
    if (mio_ready || ram_we) st++;
    cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (mio_ready || ram_we || bus_err) st++;
    end
    predict(r, w, a, d, de, e_rd, e_err, e_lat, e_we);
    check({tag, ".rdata"}, rd, e_rd);
    check({tag, ".bus_err"}, 32'(err), 32'(e_err));
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".we_pulses"}, 32'(wn), 32'(e_we));
    if (e_we != 0) begin
      check({tag, ".we_cycle"}, 32'(wc), 32'd1);
      check({tag, ".ram_addr"}, wa, 32'(a[RAM_AW+1:2]));
      check({tag, ".ram_wdata"}, wd, d);
    end
    check({tag, ".stray"}, 32'(st), 32'd0);
    check({tag, ".led_out"}, 32'(led_out), 32'(ref_led));
  endtask

  initial begin
    logic [31:0] word, d;
    int kind, sub, st;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("reset.mio_ready", 32'(mio_ready), 32'd0);
    check("reset.bus_err", 32'(bus_err), 32'd0);
    check("reset.ram_we", 32'(ram_we), 32'd0);
    check("reset.rdata", rdata, 32'd0);
    check("reset.led_out", 32'(led_out), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    clr_edge = cyc;

    // First request sampled at the first edge after release
    txn(1'b1, 1'b0, CNT_A, 32'd0, "first.cnt_rd");

    // RAM write then read
    txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, "ram.wr10");
    txn(1'b1, 1'b0, 32'h0000_0010, 32'd0, "ram.rd10");

    // LED write / readback
    txn(1'b0, 1'b1, LED_A, 32'h0000_A5A5, "led.wr");
    check("led.value", 32'(led_out), 32'h0000_A5A5);
    txn(1'b1, 1'b0, LED_A, 32'd0, "led.rd");

    // Switches: read, and a write that must be ignored
    sw_in = 16'h00FF;
    txn(1'b1, 1'b0, SW_A, 32'd0, "sw.rd");
    txn(1'b0, 1'b1, SW_A, 32'hFFFF_1234, "sw.wr");

    // Counter clear, read after idle gap, then wrap
    txn(1'b0, 1'b1, CNT_A, 32'hDEAD_0000, "cnt.clr");
    repeat (5) @(negedge clk);
    txn(1'b1, 1'b0, CNT_A, 32'd0, "cnt.rd");
    @(negedge clk);
    force dut.cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt;
    clr_edge = cyc + 1;
    txn(1'b1, 1'b0, CNT_A, 32'd0, "cnt.wrap");

    // Errors
    txn(1'b1, 1'b0, 32'h0000_0002, 32'd0, "err.misalign");
    txn(1'b1, 1'b0, 32'h1000_0000, 32'd0, "err.unmapped");
    txn(1'b1, 1'b1, 32'h0000_0010, 32'h5555_AAAA, "err.both");
    txn(1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD, "err.ram_limit");
    txn(1'b0, 1'b1, 32'h0000_0FFC, 32'h7777_0001, "ram.top_word");

    // Requests without cpu_mio are ignored
    @(negedge clk);
    mem_r = 1'b1; addr = LED_A; cpu_mio = 1'b0;
    st = 0;
    repeat (4) begin
      @(negedge clk);
      if (mio_ready || ram_we) st++;
    end
    mem_r = 1'b0;
    check("nomio.ignored", 32'(st), 32'd0);

    // Reset in the first ACCESS cycle of a RAM write
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, "rst.pre_ram");
    txn(1'b0, 1'b1, LED_A, 32'h0000_1111, "rst.pre_led");
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst.we_before", 32'(ram_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst.ram_we", 32'(ram_we), 32'd0);
    check("rst.mio_ready", 32'(mio_ready), 32'd0);
    check("rst.led_out", 32'(led_out), 32'd0);
    ref_led = 16'd0;
    cpu_mio = 1'b0; mem_w = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    clr_edge = cyc;
    st = 0;
    repeat (4) begin
      @(negedge clk);
      if (mio_ready || ram_we) st++;
    end
    check("rst.quiet", 32'(st), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'd0, "rst.ram_rd");
    txn(1'b1, 1'b0, CNT_A, 32'd0, "rst.cnt_rd");

    // Randomized traffic
    for (int i = 0; i < 64; i++) begin
      kind = $urandom_range(0, 7);
      d = $urandom;
      word = ($urandom_range(0, 3) == 0) ? 32'd1023 : 32'($urandom_range(0, 15));
      case (kind)
        0, 1: txn(1'b0, 1'b1, word << 2, d, "rand.ram_wr");
        2, 3: txn(1'b1, 1'b0, word << 2, 32'd0, "rand.ram_rd");
        4:    txn(1'b0, 1'b1, LED_A, d, "rand.led_wr");
        5:    txn(1'b1, 1'b0, LED_A, 32'd0, "rand.led_rd");
        6: begin
          sw_in = 16'($urandom);
          if ($urandom_range(0, 1) == 1) txn(1'b1, 1'b0, SW_A, 32'd0, "rand.sw_rd");
          else txn(1'b1, 1'b0, CNT_A, 32'd0, "rand.cnt_rd");
        end
        default: begin
          sub = $urandom_range(0, 4);
          case (sub)
            0: txn(1'b1, 1'b0, (word << 2) | 32'd1, 32'd0, "rand.err_align");
            1: txn(1'b1, 1'b0, 32'h0000_1000, 32'd0, "rand.err_limit");
            2: txn(1'b0, 1'b1, 32'h1000_0000, d, "rand.err_unmapped");
            3: txn(1'b1, 1'b1, word << 2, d, "rand.err_both");
            default: txn(1'b0, 1'b1, 32'hE000_000C, d, "rand.err_io");
          endcase
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
